// File: rtl/rr_arb16_if.sv
// rr_arb16_if -- request/data/grant bundle for the 16-way round-robin arbiter.
// The master side drives requests and per-requester data bits.
// The slave side (the arbiter) returns the grant, the select index and the routed data bit.
interface rr_arb16_if;
    logic [15:0] req;
    logic [15:0] data;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        gnt_valid;
    logic        out_bit;

    modport master (
        output req,
        output data,
        input  grant,
        input  sel,
        input  gnt_valid,
        input  out_bit
    );

    modport slave (
        input  req,
        input  data,
        output grant,
        output sel,
        output gnt_valid,
        output out_bit
    );
endinterface

// File: rtl/rr_arb16.sv
// rr_arb16 -- 16-requester round-robin arbiter with grant hold and a 16:1 data select.
// A granted requester keeps the grant for as long as its request stays high.
// When the grant moves, the new holder is the first requester at or after ptr.
// ptr always points one past the last grantee, so the last grantee has the lowest priority.
// Optional feature: define ARB_HOLD_LIMIT_EN to add a 3-bit hold counter.
// With the counter, a holder that has held for 8 cycles is pre-empted when another request is pending.

// mux16_1 -- the shared 16:1 single-bit select cell.
module mux16_1 (
    input  logic [15:0] d_i,
    input  logic [3:0]  s_i,
    output logic        y_o
);
    assign y_o = d_i[s_i];
endmodule

module rr_arb16 (
    input  logic      clk,
    input  logic      reset,
    rr_arb16_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state_q;
    logic [15:0] grant_q;
    logic [3:0]  sel_q;
    logic [3:0]  ptr_q;
    logic        valid_q;

    logic [15:0] searchVec;
    logic        pickFound;
    logic [3:0]  pickIdx;
    logic [3:0]  scanIdx;
    logic        holderReq;
    logic        forceMove;
    logic        muxOut;

`ifdef ARB_HOLD_LIMIT_EN
    logic [2:0]  holdCnt_q;
`endif

    // The current holder is excluded from the search, so a forced move never re-picks it.
    // When the holder releases, its request bit is already low, so excluding it changes nothing.
    // The scan runs from the farthest offset back to ptr, so the nearest hit at or after ptr wins.
    always_comb begin
        holderReq = bus.req[sel_q];
        searchVec = (state_q == HOLD) ? (bus.req & ~grant_q) : bus.req;
        pickFound = 1'b0;
        pickIdx   = ptr_q;
        scanIdx   = ptr_q;
        for (int i = 15; i >= 0; i--) begin
            scanIdx = ptr_q + 4'(i);
            if (searchVec[scanIdx]) begin
                pickFound = 1'b1;
                pickIdx   = scanIdx;
            end
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    assign forceMove = (state_q == HOLD) && holderReq && (holdCnt_q == 3'd7) && pickFound;
`else
    assign forceMove = 1'b0;
`endif

    // Arbitration state machine.
    // Every output is registered here, so there is no combinational path from req to the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 16'h0000;
            sel_q     <= 4'd0;
            ptr_q     <= 4'd0;
            valid_q   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            holdCnt_q <= 3'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickFound) begin
                        state_q   <= HOLD;
                        grant_q   <= 16'(1) << pickIdx;
                        sel_q     <= pickIdx;
                        ptr_q     <= pickIdx + 4'd1;
                        valid_q   <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                        holdCnt_q <= 3'd0;
`endif
                    end
                end
                HOLD: begin
                    if (holderReq && !forceMove) begin
`ifdef ARB_HOLD_LIMIT_EN
                        if (holdCnt_q != 3'd7) begin
                            holdCnt_q <= holdCnt_q + 3'd1;
                        end
`endif
                    end else if (pickFound) begin
                        grant_q   <= 16'(1) << pickIdx;
                        sel_q     <= pickIdx;
                        ptr_q     <= pickIdx + 4'd1;
`ifdef ARB_HOLD_LIMIT_EN
                        holdCnt_q <= 3'd0;
`endif
                    end else begin
                        state_q <= IDLE;
                        grant_q <= 16'h0000;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    mux16_1 uSelMux (
        .d_i (bus.data),
        .s_i (sel_q),
        .y_o (muxOut)
    );

    assign bus.grant     = grant_q;
    assign bus.sel       = sel_q;
    assign bus.gnt_valid = valid_q;
    assign bus.out_bit   = valid_q & muxOut;
endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16 -- scoreboard bench for rr_arb16.
// The driver applies stimulus at negedge and steps a behavioural round-robin model.
// For each stimulus it queues the outputs expected after the following posedge.
// A monitor pops the queue 2 time units after each posedge and compares the DUT outputs.
module tb_rr_arb16;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rr_arb16_if bus ();

    rr_arb16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  sel;
        logic        valid;
        logic        outBit;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // Behavioural model: who holds the grant, the rotating priority start, and how long the holder has held.
    bit mHolding;
    int mHolder;
    int mPtr;
    int mCnt;

    function automatic void modelReset();
        mHolding = 1'b0;
        mHolder  = 0;
        mPtr     = 0;
        mCnt     = 0;
    endfunction

    function automatic void modelStep(input logic [15:0] r);
        bit keep;
        bit others;
        int pick;
        int j;
        others = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (r[k] && !(mHolding && k == mHolder)) others = 1'b1;
        end
        keep = mHolding && r[mHolder];
`ifdef ARB_HOLD_LIMIT_EN
        if (keep && mCnt == 7 && others) keep = 1'b0;
`endif
        if (keep) begin
            if (mCnt < 7) mCnt = mCnt + 1;
        end else begin
            pick = -1;
            for (int k = 0; k < 16; k++) begin
                j = (mPtr + k) % 16;
                if (pick < 0 && r[j] && !(mHolding && j == mHolder)) pick = j;
            end
            if (pick >= 0) begin
                mHolder  = pick;
                mPtr     = (pick + 1) % 16;
                mHolding = 1'b1;
                mCnt     = 0;
            end else begin
                mHolding = 1'b0;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        bus.req  = r;
        bus.data = d;
        modelStep(r);
        e.grant  = mHolding ? (16'(1) << mHolder) : 16'h0000;
        e.sel    = 4'(mHolder);
        e.valid  = mHolding;
        e.outBit = mHolding ? d[mHolder] : 1'b0;
        sbQ.push_back(e);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " grant"}, 32'(bus.grant), 32'h0);
        checkOutput({tag, " sel"}, 32'(bus.sel), 32'h0);
        checkOutput({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'h0);
        checkOutput({tag, " out_bit"}, 32'(bus.out_bit), 32'h0);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.req  = 16'h0000;
        bus.data = 16'hFFFF;
        reset    = 1'b1;
        modelReset();
        #2;
        checkIdleOutputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation after every posedge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput("grant", 32'(bus.grant), 32'(e.grant));
                checkOutput("sel", 32'(bus.sel), 32'(e.sel));
                checkOutput("gnt_valid", 32'(bus.gnt_valid), 32'(e.valid));
                checkOutput("out_bit", 32'(bus.out_bit), 32'(e.outBit));
            end
        end
    end

    initial begin : stimulus
        logic [15:0] r;
        logic [15:0] prevR;
        bus.req  = 16'h0000;
        bus.data = 16'h0000;
        modelReset();

        // Single request: one-cycle latency, data routed to out_bit.
        doReset();
        applyStimulus(16'h0001, 16'h0001);
        applyStimulus(16'h0001, 16'h0001);
        applyStimulus(16'h0000, 16'h0001);
        applyStimulus(16'h0000, 16'h0001);

        // Handoffs 0 -> 8 -> 15 -> 0 with each holder dropping after two cycles.
        doReset();
        applyStimulus(16'h8101, 16'hA5A5);
        applyStimulus(16'h8101, 16'hA5A5);
        applyStimulus(16'h8100, 16'hA5A5);
        applyStimulus(16'h8101, 16'hA5A5);
        applyStimulus(16'h8001, 16'hA5A5);
        applyStimulus(16'h8101, 16'hA5A5);
        applyStimulus(16'h0101, 16'hA5A5);
        applyStimulus(16'h0000, 16'hA5A5);

        // Pointer wrap: get ptr to 15, then 15 wins before 0, then ptr wraps to 1.
        doReset();
        applyStimulus(16'h4000, 16'h0000);
        applyStimulus(16'h0000, 16'h0000);
        applyStimulus(16'h8001, 16'h8000);
        applyStimulus(16'h0001, 16'h8000);
        applyStimulus(16'h0000, 16'h0000);
        applyStimulus(16'h0003, 16'h0002);
        applyStimulus(16'h0000, 16'h0000);

        // Asynchronous reset mid-hold at sel 5, then restart from ptr 0.
        doReset();
        applyStimulus(16'h0020, 16'hFFFF);
        applyStimulus(16'h0020, 16'hFFFF);
        applyStimulus(16'h0020, 16'hFFFF);
        @(posedge clk);
        #3;
        reset = 1'b1;
        modelReset();
        #1;
        checkIdleOutputs("async reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(16'h0060, 16'h0020);
        applyStimulus(16'h0060, 16'h0020);
        applyStimulus(16'h0000, 16'h0020);

        // Constant 0x0003 request.
        doReset();
        for (int c = 0; c < 20; c++) applyStimulus(16'h0003, 16'h0001);
        applyStimulus(16'h0000, 16'h0001);

        // Data routing for every requester in turn, plus idle gating.
        doReset();
        for (int i = 0; i < 16; i++) begin
            r = 16'(1) << i;
            applyStimulus(r, 16'h39CA);
            applyStimulus(r, 16'h39CA);
            applyStimulus(16'h0000, 16'h39CA);
        end

        // Randomised traffic mixing idle, single, sparse and slowly changing request patterns.
        doReset();
        prevR = 16'h0000;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 4))
                0: r = 16'h0000;
                1: r = 16'(1) << $urandom_range(0, 15);
                2: r = 16'($urandom) & 16'($urandom);
                default: r = prevR ^ (16'(1) << $urandom_range(0, 15));
            endcase
            prevR = r;
            applyStimulus(r, 16'($urandom));
        end
        applyStimulus(16'h0000, 16'h0000);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/rr_arb16.md
RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 The block SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL have port: req  input  16  request per requester; bit i is requester i.
REQ-004 The block SHALL have port: data  input  16  one data bit per requester, routed to out_bit by the granted select.
REQ-005 The block SHALL have port: grant  output  16  one-hot grant; all-zero when idle.
REQ-006 The block SHALL have port: sel  output  4  binary index of the current/last grantee; drives the 16:1 select.
REQ-007 The block SHALL have port: gnt_valid  output  1  high while a grant is held.
REQ-008 The block SHALL have port: out_bit  output  1  data[sel] when gnt_valid is high, 0 otherwise.

Function
REQ-009 The block SHALL implement two states, IDLE and HOLD, in a registered state machine.
REQ-010 In IDLE with req != 0, the block SHALL pick the first asserted requester at or after ptr, cyclic 15->0, and enter HOLD at the next edge (1-cycle req-to-grant latency).
REQ-011 In IDLE with req == 0, the block SHALL stay in IDLE with grant = 0 and gnt_valid = 0.
REQ-012 In HOLD, the grant SHALL remain unchanged while req[sel] stays high, regardless of other requests.
REQ-013 In HOLD, when req[sel] is low at an edge and other requests are pending, the grant SHALL move directly to the next winner at that edge, with no idle bubble.
REQ-014 In HOLD, when req[sel] is low at an edge and no request is pending, the block SHALL go to IDLE with grant = 0 and gnt_valid = 0; sel SHALL keep its last value.
REQ-015 On every new grant to index k, ptr SHALL update to (k+1) mod 16 (4-bit wrap), so the last grantee has lowest priority.
REQ-016 The re-arbitration search SHALL start at ptr; a requester that drops and re-asserts in the same cycle SHALL be treated as a new request.
REQ-017 grant SHALL equal the one-hot decode of sel whenever gnt_valid = 1, and exactly one grant bit SHALL be high in HOLD.
REQ-018 out_bit SHALL be combinational from data through a 16:1 mux built from the team's existing mux16_1 cell, gated with gnt_valid.
REQ-019 grant, sel and gnt_valid SHALL be registered outputs with no combinational path from req.

Reset
REQ-020 While reset is high, state SHALL be IDLE, grant = 16'h0000, sel = 0, ptr = 0, gnt_valid = 0 and out_bit = 0, independent of clk.
REQ-021 Reset asserted mid-HOLD SHALL drop the grant immediately (asynchronously); after release, arbitration SHALL restart from ptr = 0 at the first edge.

Configuration
REQ-022 Macro ARB_HOLD_LIMIT_EN, when defined, SHALL add a 3-bit hold counter that clears on each new grant and increments each HOLD cycle.
REQ-023 With ARB_HOLD_LIMIT_EN defined, after 8 consecutive HOLD cycles with another request pending, the grant SHALL be forcibly moved to the next winner after sel, even if req[sel] is still high.
REQ-024 With ARB_HOLD_LIMIT_EN defined and no other request pending, the holder SHALL keep the grant and the counter SHALL saturate at 7.
REQ-025 Without ARB_HOLD_LIMIT_EN, there SHALL be no counter, and a holder SHALL keep the grant indefinitely.

Verification
REQ-026 Reset, then req = 16'h0001 -> one edge later grant = 16'h0001, sel = 0, gnt_valid = 1; with data = 16'h0001, out_bit = 1.
REQ-027 req = 16'h8101 held, with each holder dropping after 2 cycles -> grants are issued in order 0, 8, 15, 0, with no idle cycle between handoffs.
REQ-028 Starting from ptr = 15, req = 16'h8001 -> grant goes to 15 first, then to 0, and ptr wraps to 1.
REQ-029 Assert reset asynchronously mid-HOLD at sel = 5 -> grant = 0 and gnt_valid = 0 before the next edge; after release, req = 16'h0060 -> grant to 5.
REQ-030 With ARB_HOLD_LIMIT_EN defined, req = 16'h0003 held constantly -> grant alternates 0 and 1 every 8 cycles; without the macro, requester 0 holds the grant for the whole run.
REQ-031 data = 16'h39CA, holding each single requester i = 0..15 in turn -> out_bit = data[i] while granted, and out_bit = 0 when idle.
